// File: rtl/mc_ctrl_pkg.sv
//------------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle ARM control unit:
//   - state_t      : 4-bit FSM state encoding (also exported on state_dbg)
//   - ALU_*        : ALUControl codes driven onto the datapath
//   - COND_*       : ARM condition field values
//   - OP_*         : Instr[27:26] instruction class values
//   - FN_*         : Funct[4:1] data-processing command values
//   - cond_eval()  : ARMv4 condition check against an NZCV vector
//   - alu_decode() : Funct[4:1] to ALUControl mapping
//------------------------------------------------------------------------------
`timescale 1ns/1ps

package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_HALT   = 4'd10,
      S_ERROR  = 4'd11
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_ORR = 4'b1100;
   localparam logic [3:0] ALU_MOV = 4'b1101;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   localparam logic [3:0] FN_AND = 4'b0000;
   localparam logic [3:0] FN_SUB = 4'b0010;
   localparam logic [3:0] FN_ADD = 4'b0100;
   localparam logic [3:0] FN_CMP = 4'b1010;
   localparam logic [3:0] FN_ORR = 4'b1100;
   localparam logic [3:0] FN_MOV = 4'b1101;

   // nzcv is packed {N,Z,C,V}. The never-condition encoding is executed
   // unconditionally, the same as AL.
   function automatic logic cond_eval(input logic [3:0] cond,
                                      input logic [3:0] nzcv);
      logic n, z, c, v;
      logic res;
      n = nzcv[3];
      z = nzcv[2];
      c = nzcv[1];
      v = nzcv[0];
      case (cond)
         COND_EQ: res = z;
         COND_NE: res = ~z;
         COND_CS: res = c;
         COND_CC: res = ~c;
         COND_MI: res = n;
         COND_PL: res = ~n;
         COND_VS: res = v;
         COND_VC: res = ~v;
         COND_HI: res = c & ~z;
         COND_LS: res = ~c | z;
         COND_GE: res = (n == v);
         COND_LT: res = (n != v);
         COND_GT: res = ~z & (n == v);
         COND_LE: res = z | (n != v);
         default: res = 1'b1;
      endcase
      return res;
   endfunction

   // Unlisted commands fall back to ADD so the datapath always sees a
   // defined operation.
   function automatic logic [3:0] alu_decode(input logic [3:0] cmd);
      logic [3:0] res;
      case (cmd)
         FN_ADD:  res = ALU_ADD;
         FN_SUB:  res = ALU_SUB;
         FN_CMP:  res = ALU_SUB;
         FN_AND:  res = ALU_AND;
         FN_ORR:  res = ALU_ORR;
         FN_MOV:  res = ALU_MOV;
         default: res = ALU_ADD;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mc_cond_unit.sv
//------------------------------------------------------------------------------
// mc_cond_unit
// Holds the NZCV flag register and evaluates the instruction condition
// against the stored flags.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset, clears the flags
//   flag_we    in   load alu_flags into the flag register at the clock edge
//   alu_flags  in   {N,Z,C,V} produced by the ALU this cycle
//   cond       in   Instr[31:28]
//   cond_ex    out  condition passes against the stored flags
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module mc_cond_unit
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       flag_we,
   input  logic [3:0] alu_flags,
   input  logic [3:0] cond,
   output logic       cond_ex
);

   logic [3:0] flags_q;
   logic [3:0] flags_d;

   always_comb begin
      flags_d = flags_q;
      if (flag_we) begin
         flags_d = alu_flags;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_q <= 4'b0000;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign cond_ex = cond_eval(cond, flags_q);

endmodule

// File: rtl/mc_control_fsm.sv
//------------------------------------------------------------------------------
// mc_control_fsm
// Multi-cycle ARM control unit with a variable-latency memory handshake,
// wait timeout, debug halt/single-step and an internal NZCV register.
// Ports:
//   clk, reset               clock (rising edge), async active-low reset
//   Cond, Op, Funct, Rd      instruction fields from the instruction register
//   ALUFlags                 {N,Z,C,V} from the ALU this cycle
//   mem_ready                memory completes the access presented this cycle
//   halt_req, step           debug halt request (level) and single-step pulse
//   PCWrite .. ALUControl    datapath control bus
//   mem_req                  memory access request
//   halted, mem_err          debug halt indicator, sticky timeout error
//   state_dbg                current state encoding
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_MAX      = 16,
   parameter int unsigned CNT_W         = 8,
   parameter bit          HALT_ON_RESET = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   input  logic       mem_ready,
   input  logic       halt_req,
   input  logic       step,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic       BL_ctrl,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [3:0] ALUControl,
   output logic       mem_req,
   output logic       halted,
   output logic       mem_err,
   output logic [3:0] state_dbg
);

   localparam state_t RESET_STATE = HALT_ON_RESET ? S_HALT : S_FETCH;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic               mem_err_q, mem_err_d;

   logic               cond_ex;
   logic               flag_we;
   logic               mem_state;
   logic               timeout;
   logic               is_cmp;
   logic               enter_wait_state;

   // Flags load at the end of an execute cycle when the S bit is set.
   assign flag_we = ((state_q == S_EXECR) || (state_q == S_EXECI)) && Funct[0];

   mc_cond_unit u_cond (
      .clk       (clk),
      .reset     (reset),
      .flag_we   (flag_we),
      .alu_flags (ALUFlags),
      .cond      (Cond),
      .cond_ex   (cond_ex)
   );

   assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                      (state_q == S_MEMWR);
   assign is_cmp    = (Funct[4:1] == FN_CMP);

   // A ready in the same cycle the limit is reached still completes the
   // access, so the timeout also requires mem_ready low.
   assign timeout = (WAIT_MAX != 0) && mem_state && !mem_ready &&
                    (wait_cnt_q == CNT_W'(WAIT_MAX));

   // Next-state logic. The halt diversion at the bottom only applies to a
   // real transition into FETCH, so an in-progress fetch wait is never cut
   // short and leaving HALT through step is not undone.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (timeout) begin
               state_d = S_ERROR;
            end
         end
         S_DECODE: begin
            if (!cond_ex) begin
               state_d = S_FETCH;
            end else begin
               case (Op)
                  OP_MEM:  state_d = S_MEMADR;
                  OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                  OP_BR:   state_d = S_BRANCH;
                  default: state_d = S_FETCH;
               endcase
            end
         end
         S_EXECR, S_EXECI: state_d = S_ALUWB;
         S_ALUWB:          state_d = S_FETCH;
         S_MEMADR:         state_d = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD: begin
            if (mem_ready) begin
               state_d = S_MEMWB;
            end else if (timeout) begin
               state_d = S_ERROR;
            end
         end
         S_MEMWB:          state_d = S_FETCH;
         S_MEMWR: begin
            if (mem_ready) begin
               state_d = S_FETCH;
            end else if (timeout) begin
               state_d = S_ERROR;
            end
         end
         S_BRANCH:         state_d = S_FETCH;
         S_HALT: begin
            if (step || !halt_req) begin
               state_d = S_FETCH;
            end
         end
         S_ERROR:          state_d = S_ERROR;
         default:          state_d = S_ERROR;
      endcase

      if ((state_d == S_FETCH) && (state_q != S_FETCH) &&
          (state_q != S_HALT) && halt_req) begin
         state_d = S_HALT;
      end
   end

   // Wait counter restarts on entry to each memory-requesting state and
   // saturates rather than wrapping while the memory stalls.
   assign enter_wait_state = (state_d != state_q) &&
                             ((state_d == S_FETCH) || (state_d == S_MEMRD) ||
                              (state_d == S_MEMWR));

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (enter_wait_state) begin
         wait_cnt_d = '0;
      end else if (mem_state && !mem_ready && (wait_cnt_q != '1)) begin
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
   end

   // ERROR is only left through reset, so the error flag just latches.
   always_comb begin
      mem_err_d = mem_err_q | (state_d == S_ERROR);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RESET_STATE;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   // Moore decode of the control bus. ImmSrc/RegSrc follow the instruction
   // from DECODE through the end of the instruction because the datapath
   // extends the immediate combinationally in the execute states too.
   // The final block forces the bus quiet while reset is held, which is what
   // abandons an in-flight store without a write.
   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      BL_ctrl    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcB    = 2'b00;
      ImmSrc     = 2'b00;
      RegSrc     = 2'b00;
      ALUControl = ALU_AND;
      mem_req    = 1'b0;

      case (state_q)
         S_DECODE, S_EXECR, S_EXECI, S_ALUWB, S_MEMADR,
         S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH: begin
            ImmSrc = Op;
            RegSrc = {(Op == OP_MEM), (Op == OP_BR)};
         end
         default: ;
      endcase

      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            ALUControl = ALU_ADD;
            IRWrite    = mem_ready;
            PCWrite    = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            ALUControl = ALU_ADD;
         end
         S_EXECR: begin
            ALUControl = alu_decode(Funct[4:1]);
         end
         S_EXECI: begin
            ALUSrcB    = 2'b01;
            ALUControl = alu_decode(Funct[4:1]);
         end
         S_ALUWB: begin
            RegWrite = !is_cmp;
            PCWrite  = (Rd == 4'd15) && !is_cmp;
         end
         S_MEMADR: begin
            ALUSrcB    = 2'b01;
            ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcB    = 2'b01;
            ALUControl = ALU_ADD;
            ResultSrc  = 2'b10;
            PCWrite    = 1'b1;
            BL_ctrl    = Funct[4];
            RegWrite   = Funct[4];
         end
         default: ;
      endcase

      if (!reset) begin
         PCWrite    = 1'b0;
         AdrSrc     = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         RegWrite   = 1'b0;
         ALUSrcA    = 1'b0;
         BL_ctrl    = 1'b0;
         ResultSrc  = 2'b00;
         ALUSrcB    = 2'b00;
         ImmSrc     = 2'b00;
         RegSrc     = 2'b00;
         ALUControl = 4'b0000;
         mem_req    = 1'b0;
      end
   end

   assign halted    = (state_q == S_HALT);
   assign mem_err   = mem_err_q;
   assign state_dbg = reset ? state_q : 4'b0000;

endmodule

// File: tb/tb_mc_control_fsm.sv
//------------------------------------------------------------------------------
// tb_mc_control_fsm
// Directed-vector bench for mc_control_fsm (WAIT_MAX=4). The bench plays the
// instruction register and memory: it presents instruction fields and
// mem_ready each cycle and compares the control bus to hand-computed values.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mc_control_fsm;

   localparam logic [3:0] ST_FETCH  = 4'd0;
   localparam logic [3:0] ST_DECODE = 4'd1;
   localparam logic [3:0] ST_MEMADR = 4'd2;
   localparam logic [3:0] ST_MEMRD  = 4'd3;
   localparam logic [3:0] ST_MEMWB  = 4'd4;
   localparam logic [3:0] ST_MEMWR  = 4'd5;
   localparam logic [3:0] ST_EXECR  = 4'd6;
   localparam logic [3:0] ST_EXECI  = 4'd7;
   localparam logic [3:0] ST_ALUWB  = 4'd8;
   localparam logic [3:0] ST_BRANCH = 4'd9;
   localparam logic [3:0] ST_HALT   = 4'd10;
   localparam logic [3:0] ST_ERROR  = 4'd11;

   logic       clk;
   logic       reset;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       mem_ready;
   logic       halt_req;
   logic       step;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, BL_ctrl;
   logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
   logic [3:0] ALUControl;
   logic       mem_req, halted, mem_err;
   logic [3:0] state_dbg;

   int totalChecks;
   int badChecks;
   int memReqCycles;

   mc_control_fsm #(
      .WAIT_MAX      (4),
      .CNT_W         (8),
      .HALT_ON_RESET (1'b0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .Cond       (Cond),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .ALUFlags   (ALUFlags),
      .mem_ready  (mem_ready),
      .halt_req   (halt_req),
      .step       (step),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .BL_ctrl    (BL_ctrl),
      .ResultSrc  (ResultSrc),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .ALUControl (ALUControl),
      .mem_req    (mem_req),
      .halted     (halted),
      .mem_err    (mem_err),
      .state_dbg  (state_dbg)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance to just after the next rising edge; inputs are then changed and
   // outputs sampled a further 1 ns later, well away from the edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [3:0] c, input logic [1:0] o,
                                input logic [5:0] f, input logic [3:0] r);
      Cond  = c;
      Op    = o;
      Funct = f;
      Rd    = r;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      totalChecks  = 0;
      badChecks    = 0;
      memReqCycles = 0;
      reset     = 1'b0;
      ALUFlags  = 4'b0000;
      mem_ready = 1'b0;
      halt_req  = 1'b0;
      step      = 1'b0;
      applyStimulus(4'b0000, 2'b00, 6'b000000, 4'd0);

      // Reset: bus quiet even with mem_ready high.
      cyc();
      cyc();
      mem_ready = 1'b1;
      #1;
      checkOutput("rst_mem_req", mem_req, 0);
      checkOutput("rst_irwrite", IRWrite, 0);
      checkOutput("rst_pcwrite", PCWrite, 0);
      checkOutput("rst_halted", halted, 0);
      checkOutput("rst_mem_err", mem_err, 0);
      checkOutput("rst_state", state_dbg, 0);

      // ADD R1,R2,R3 with memory always ready.
      cyc();
      reset = 1'b1;
      applyStimulus(4'b1110, 2'b00, 6'b001000, 4'd1);
      #1;
      checkOutput("add_fetch_state", state_dbg, ST_FETCH);
      checkOutput("add_fetch_irw", IRWrite, 1);
      checkOutput("add_fetch_pcw", PCWrite, 1);
      checkOutput("add_fetch_req", mem_req, 1);
      checkOutput("add_fetch_srcb", ALUSrcB, 2'b10);
      checkOutput("add_fetch_rw", RegWrite, 0);
      cyc(); #1;
      checkOutput("add_dec_state", state_dbg, ST_DECODE);
      checkOutput("add_dec_rw", RegWrite, 0);
      checkOutput("add_dec_req", mem_req, 0);
      cyc(); #1;
      checkOutput("add_ex_state", state_dbg, ST_EXECR);
      checkOutput("add_ex_aluc", ALUControl, 4'b0100);
      checkOutput("add_ex_srca", ALUSrcA, 0);
      checkOutput("add_ex_srcb", ALUSrcB, 2'b00);
      checkOutput("add_ex_rw", RegWrite, 0);
      cyc(); #1;
      checkOutput("add_wb_state", state_dbg, ST_ALUWB);
      checkOutput("add_wb_rw", RegWrite, 1);
      checkOutput("add_wb_pcw", PCWrite, 0);
      checkOutput("add_wb_res", ResultSrc, 2'b00);

      // LDR R2 with a 3-cycle memory delay in MEMRD.
      cyc();
      applyStimulus(4'b1110, 2'b01, 6'b011001, 4'd2);
      #1;
      checkOutput("ldr_fetch_state", state_dbg, ST_FETCH);
      checkOutput("ldr_fetch_irw", IRWrite, 1);
      cyc(); #1;
      checkOutput("ldr_dec_state", state_dbg, ST_DECODE);
      checkOutput("ldr_dec_imm", ImmSrc, 2'b01);
      checkOutput("ldr_dec_regsrc", RegSrc, 2'b10);
      cyc();
      mem_ready = 1'b0;
      #1;
      checkOutput("ldr_adr_state", state_dbg, ST_MEMADR);
      checkOutput("ldr_adr_aluc", ALUControl, 4'b0100);
      checkOutput("ldr_adr_srcb", ALUSrcB, 2'b01);
      for (int i = 0; i < 4; i++) begin
         cyc();
         mem_ready = (i == 3);
         #1;
         checkOutput("ldr_rd_state", state_dbg, ST_MEMRD);
         checkOutput("ldr_rd_adrsrc", AdrSrc, 1);
         checkOutput("ldr_rd_irw", IRWrite, 0);
         if (mem_req) memReqCycles++;
      end
      checkOutput("ldr_req_cycles", memReqCycles, 4);
      cyc(); #1;
      checkOutput("ldr_wb_state", state_dbg, ST_MEMWB);
      checkOutput("ldr_wb_rw", RegWrite, 1);
      checkOutput("ldr_wb_res", ResultSrc, 2'b01);
      checkOutput("ldr_wb_req", mem_req, 0);

      // CMP R15-form sets Z; fetch waits one cycle first.
      cyc();
      mem_ready = 1'b0;
      applyStimulus(4'b1110, 2'b00, 6'b010101, 4'd15);
      #1;
      checkOutput("cmp_fwait_state", state_dbg, ST_FETCH);
      checkOutput("cmp_fwait_irw", IRWrite, 0);
      checkOutput("cmp_fwait_pcw", PCWrite, 0);
      cyc();
      mem_ready = 1'b1;
      #1;
      checkOutput("cmp_fetch_irw", IRWrite, 1);
      cyc(); #1;
      checkOutput("cmp_dec_state", state_dbg, ST_DECODE);
      cyc();
      ALUFlags = 4'b0100;
      #1;
      checkOutput("cmp_ex_state", state_dbg, ST_EXECR);
      checkOutput("cmp_ex_aluc", ALUControl, 4'b0010);
      cyc();
      ALUFlags = 4'b0000;
      #1;
      checkOutput("cmp_wb_state", state_dbg, ST_ALUWB);
      checkOutput("cmp_wb_rw", RegWrite, 0);
      checkOutput("cmp_wb_pcw", PCWrite, 0);

      // BNE with Z=1: not taken.
      cyc();
      applyStimulus(4'b0001, 2'b10, 6'b000000, 4'd0);
      #1;
      checkOutput("bne_fetch_state", state_dbg, ST_FETCH);
      cyc(); #1;
      checkOutput("bne_dec_state", state_dbg, ST_DECODE);
      checkOutput("bne_dec_imm", ImmSrc, 2'b10);
      checkOutput("bne_dec_regsrc", RegSrc, 2'b01);
      checkOutput("bne_dec_pcw", PCWrite, 0);
      cyc();
      applyStimulus(4'b0000, 2'b10, 6'b010000, 4'd0);
      #1;
      checkOutput("bne_skip_state", state_dbg, ST_FETCH);

      // BL EQ with Z=1: taken, link written.
      cyc(); #1;
      checkOutput("beq_dec_state", state_dbg, ST_DECODE);
      cyc(); #1;
      checkOutput("beq_br_state", state_dbg, ST_BRANCH);
      checkOutput("beq_br_pcw", PCWrite, 1);
      checkOutput("beq_br_rw", RegWrite, 1);
      checkOutput("beq_br_bl", BL_ctrl, 1);
      checkOutput("beq_br_res", ResultSrc, 2'b10);
      checkOutput("beq_br_aluc", ALUControl, 4'b0100);

      // MOVS immediate loads N=1 (clearing Z).
      cyc();
      applyStimulus(4'b1110, 2'b00, 6'b111011, 4'd3);
      #1;
      checkOutput("movs_fetch_state", state_dbg, ST_FETCH);
      cyc(); #1;
      cyc();
      ALUFlags = 4'b1000;
      #1;
      checkOutput("movs_ex_state", state_dbg, ST_EXECI);
      checkOutput("movs_ex_srcb", ALUSrcB, 2'b01);
      checkOutput("movs_ex_aluc", ALUControl, 4'b1101);
      cyc();
      ALUFlags = 4'b0000;
      #1;
      checkOutput("movs_wb_rw", RegWrite, 1);

      // BGE with N=1,V=0: not taken.
      cyc();
      applyStimulus(4'b1010, 2'b10, 6'b000000, 4'd0);
      #1;
      cyc(); #1;
      checkOutput("bge_dec_state", state_dbg, ST_DECODE);
      cyc();
      applyStimulus(4'b1111, 2'b00, 6'b001000, 4'd1);
      #1;
      checkOutput("bge_skip_state", state_dbg, ST_FETCH);

      // ADD with Cond=1111 (always), halt requested mid-instruction.
      cyc(); #1;
      cyc();
      halt_req = 1'b1;
      #1;
      checkOutput("halt_ex_state", state_dbg, ST_EXECR);
      cyc(); #1;
      checkOutput("halt_wb_state", state_dbg, ST_ALUWB);
      checkOutput("halt_wb_rw", RegWrite, 1);
      cyc();
      applyStimulus(4'b1110, 2'b11, 6'b000000, 4'd0);
      #1;
      checkOutput("halt_state", state_dbg, ST_HALT);
      checkOutput("halt_halted", halted, 1);
      checkOutput("halt_req_out", mem_req, 0);
      checkOutput("halt_srca", ALUSrcA, 0);
      cyc();
      step = 1'b1;
      #1;
      checkOutput("halt_hold_state", state_dbg, ST_HALT);
      cyc();
      step = 1'b0;
      #1;
      checkOutput("step_fetch_state", state_dbg, ST_FETCH);
      checkOutput("step_fetch_halted", halted, 0);
      cyc(); #1;
      checkOutput("step_dec_state", state_dbg, ST_DECODE);
      cyc(); #1;
      checkOutput("step_rehalt_state", state_dbg, ST_HALT);
      checkOutput("step_rehalt_halted", halted, 1);
      cyc();
      halt_req = 1'b0;
      #1;
      checkOutput("unhalt_hold_state", state_dbg, ST_HALT);

      // STR with SUB offset, reset asserted while the store waits.
      cyc();
      applyStimulus(4'b1110, 2'b01, 6'b010000, 4'd4);
      #1;
      checkOutput("str_fetch_state", state_dbg, ST_FETCH);
      cyc(); #1;
      cyc();
      mem_ready = 1'b0;
      #1;
      checkOutput("str_adr_state", state_dbg, ST_MEMADR);
      checkOutput("str_adr_aluc", ALUControl, 4'b0010);
      cyc(); #1;
      checkOutput("str_wr_state", state_dbg, ST_MEMWR);
      checkOutput("str_wr_memw", MemWrite, 1);
      checkOutput("str_wr_req", mem_req, 1);
      cyc();
      reset     = 1'b0;
      mem_ready = 1'b1;
      #1;
      checkOutput("str_rst_memw", MemWrite, 0);
      checkOutput("str_rst_req", mem_req, 0);
      checkOutput("str_rst_state", state_dbg, 0);
      cyc(); #1;
      checkOutput("str_rst2_memw", MemWrite, 0);

      // Fetch whose ready arrives exactly at the wait limit completes.
      cyc();
      reset     = 1'b1;
      mem_ready = 1'b0;
      applyStimulus(4'b1110, 2'b11, 6'b000000, 4'd0);
      #1;
      checkOutput("post_rst_state", state_dbg, ST_FETCH);
      checkOutput("post_rst_memw", MemWrite, 0);
      checkOutput("post_rst_req", mem_req, 1);
      for (int i = 1; i < 4; i++) begin
         cyc(); #1;
         checkOutput("edge_wait_state", state_dbg, ST_FETCH);
      end
      cyc();
      mem_ready = 1'b1;
      #1;
      checkOutput("edge_ready_state", state_dbg, ST_FETCH);
      checkOutput("edge_ready_irw", IRWrite, 1);
      cyc(); #1;
      checkOutput("edge_dec_state", state_dbg, ST_DECODE);

      // Fetch that never completes times out into ERROR.
      cyc();
      mem_ready = 1'b0;
      #1;
      checkOutput("to_c0_state", state_dbg, ST_FETCH);
      for (int i = 1; i <= 4; i++) begin
         cyc(); #1;
         checkOutput("to_wait_state", state_dbg, ST_FETCH);
         checkOutput("to_wait_pcw", PCWrite, 0);
      end
      cyc(); #1;
      checkOutput("to_err_state", state_dbg, ST_ERROR);
      checkOutput("to_err_flag", mem_err, 1);
      checkOutput("to_err_req", mem_req, 0);
      checkOutput("to_err_pcw", PCWrite, 0);
      cyc();
      mem_ready = 1'b1;
      #1;
      cyc(); #1;
      checkOutput("to_sticky_state", state_dbg, ST_ERROR);
      checkOutput("to_sticky_flag", mem_err, 1);
      checkOutput("to_sticky_pcw", PCWrite, 0);
      cyc();
      reset = 1'b0;
      #1;
      checkOutput("to_rst_flag", mem_err, 0);
      cyc();
      reset = 1'b1;
      #1;
      checkOutput("to_rel_state", state_dbg, ST_FETCH);
      checkOutput("to_rel_flag", mem_err, 0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
